// File: rtl/decoder_2to4.sv
// Enable-gated 2-to-4 one-hot decoder, MSB-first: sel {b,a}=00 lights out[3].
// OUT_REG selects a registered (1-cycle, async-cleared) or purely combinational output.
module decoder_2to4 #(
   parameter bit OUT_REG = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       a,
   input  logic       b,
   input  logic       en,
   output logic [3:0] out
);

   logic [3:0] dec_d;

   // en=0 masks the select entirely, so X on a/b never leaks out while disabled.
   always_comb begin
      dec_d = 4'b0000;
      if (en) dec_d = 4'b1000 >> {b, a};
   end

   generate
      if (OUT_REG) begin : g_reg
         logic [3:0] out_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) out_q <= 4'b0000;
            else        out_q <= dec_d;
         end

         assign out = out_q;
      end else begin : g_comb
         logic unused_clk_rst;

         assign unused_clk_rst = clk ^ rst_n;
         assign out            = dec_d;
      end
   endgenerate

endmodule

// File: tb/tb_decoder_2to4.sv
// Bench for decoder_2to4: directed reset/sweep/toggle steps plus a random run,
// both OUT_REG variants checked against a table-style reference decode.
module tb_decoder_2to4;

   logic       clk;
   logic       rst_n;
   logic       a, b, en;
   logic [3:0] out_r;
   logic [3:0] out_c;
   int         n_cmp = 0;
   int         n_err = 0;

   decoder_2to4 #(.OUT_REG(1'b1)) u_reg (
      .clk(clk), .rst_n(rst_n), .a(a), .b(b), .en(en), .out(out_r)
   );

   decoder_2to4 #(.OUT_REG(1'b0)) u_comb (
      .clk(clk), .rst_n(rst_n), .a(a), .b(b), .en(en), .out(out_c)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: select value picks which bit (counted from the MSB) is lit.
   function automatic logic [3:0] ref_dec(input logic e, input logic aa, input logic bb);
      int idx;
      ref_dec = 4'b0000;
      if (e) begin
         idx = 3 - (2 * int'(bb) + int'(aa));
         ref_dec[idx] = 1'b1;
      end
   endfunction

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk_oh(input string tag, input logic [3:0] obs);
      n_cmp++;
      assert ($onehot0(obs) === 1'b1) else begin
         n_err++;
         $error("FAIL %s: observed %b expected at most one bit set", tag, obs);
      end
   endtask

   // Apply a vector just after an edge, check comb immediately, reg after the next edge.
   task automatic cyc(input string tag, input logic e, input logic aa, input logic bb);
      logic [3:0] exp;
      exp = ref_dec(e, aa, bb);
      en = e; a = aa; b = bb;
      #1;
      chk({tag, "_comb"}, out_c, exp);
      chk_oh({tag, "_comb_oh"}, out_c);
      @(posedge clk);
      #1;
      chk({tag, "_reg"}, out_r, exp);
      chk_oh({tag, "_reg_oh"}, out_r);
   endtask

   initial begin
      // Reset with sel=11 enabled, before any clock edge.
      rst_n = 1'b0; en = 1'b1; a = 1'b1; b = 1'b1;
      #2;
      chk("reset_async", out_r, 4'b0000);
      chk("reset_comb_ignores", out_c, 4'b0001);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("reset_release_first", out_r, 4'b0001);

      // Disabled sweep.
      cyc("dis00", 1'b0, 1'b0, 1'b0);
      cyc("dis01", 1'b0, 1'b1, 1'b0);
      cyc("dis10", 1'b0, 1'b0, 1'b1);
      cyc("dis11", 1'b0, 1'b1, 1'b1);

      // Enabled sweep.
      cyc("en00", 1'b1, 1'b0, 1'b0);
      chk("en00_const", out_r, 4'b1000);
      cyc("en01", 1'b1, 1'b1, 1'b0);
      chk("en01_const", out_r, 4'b0100);
      cyc("en10", 1'b1, 1'b0, 1'b1);
      chk("en10_const", out_r, 4'b0010);
      cyc("en11", 1'b1, 1'b1, 1'b1);
      chk("en11_const", out_r, 4'b0001);

      // Enable toggle with a=1,b=0.
      cyc("tog1", 1'b1, 1'b1, 1'b0);
      cyc("tog0", 1'b0, 1'b1, 1'b0);
      cyc("tog1b", 1'b1, 1'b1, 1'b0);

      // en=0 must mask unknown selects.
      cyc("dis_x", 1'b0, 1'bx, 1'bx);

      // Latency: output must still hold the old value before the edge.
      cyc("lat_a", 1'b1, 1'b0, 1'b0);
      en = 1'b1; a = 1'b1; b = 1'b1;
      #1;
      chk("lat_hold", out_r, 4'b1000);
      @(posedge clk); #1;
      chk("lat_load", out_r, 4'b0001);

      // Mid-stream reset between edges, held across one edge.
      #2 rst_n = 1'b0;
      #1;
      chk("mid_reset_async", out_r, 4'b0000);
      @(posedge clk); #1;
      chk("mid_reset_hold", out_r, 4'b0000);
      chk("mid_reset_comb", out_c, 4'b0001);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("mid_reset_recover", out_r, 4'b0001);

      // Random run.
      for (int i = 0; i < 1000; i++) begin
         cyc("rand", 1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
